tick_sel_mux: RTL
=================

TICK_SEL_MUX -- requirements
Module: tick_sel_mux

Interface
REQ-001 Parameter N, default 4: number of tick channels, range 2..16.
REQ-002 Parameter SW, default 2: select width, with N <= 2**SW.
REQ-003 Parameter TMO, default 1024: timeout in clock cycles for each switch phase, range >= 2.
REQ-004 Parameter RST_SEL, default 0: channel selected after reset, with RST_SEL < N.
REQ-005 Port CLK, input, 1 bit: the single system clock; all state changes on the rising edge.
REQ-006 Port RST, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port TICK_IN, input, N bits: one-cycle enable pulses per channel, synchronous to CLK.
REQ-008 Port SEL, input, SW bits: requested channel, sampled only when SEL_REQ=1.
REQ-009 Port SEL_REQ, input, 1 bit: one-cycle switch request strobe.
REQ-010 Port TICK_OUT, output, 1 bit: registered selected tick.
REQ-011 Port CUR_SEL, output, SW bits: currently committed channel.
REQ-012 Port BUSY, output, 1 bit: high while a switch is in progress.
REQ-013 Port SWITCHED, output, 1 bit: one-cycle pulse when a switch completes normally.
REQ-014 Port ERR, output, 1 bit: one-cycle pulse on an invalid request or a timeout.

Function
REQ-015 States SHALL be RUN, WAIT_OLD and WAIT_NEW; BUSY = (state != RUN).
REQ-016 Latency: TICK_OUT(t+1) SHALL equal the gated selected tick at cycle t; fixed 1-cycle latency, no combinational path from input to output.
REQ-017 RUN: TICK_OUT(t+1) = TICK_IN[CUR_SEL](t).
REQ-018 RUN, SEL_REQ=1, SEL<N and SEL!=CUR_SEL:
- latch PEND=SEL;
- clear the timeout counter;
- go to WAIT_OLD.
- The tick of this same cycle is still forwarded from CUR_SEL.
REQ-019 RUN, SEL_REQ=1, SEL==CUR_SEL: no state change, no SWITCHED, no ERR.
REQ-020 SEL_REQ=1 with SEL>=N, in any state: request ignored; ERR pulses in the next cycle.
REQ-021 SEL_REQ=1 with a valid SEL while BUSY: request ignored, no ERR, PEND unchanged.
REQ-022 WAIT_OLD:
- forward TICK_IN[CUR_SEL];
- on the cycle that tick is 1, forward it, clear the counter and go to WAIT_NEW.
REQ-023 WAIT_NEW:
- forward nothing from CUR_SEL;
- on the first cycle with TICK_IN[PEND]=1, forward it, set CUR_SEL=PEND, pulse SWITCHED and go to RUN.
REQ-024 Simultaneous old and new ticks in WAIT_OLD: only the old tick is forwarded; the new tick of that cycle does not complete the switch.
REQ-025 No-glitch guarantee: TICK_OUT SHALL never be 1 on two consecutive cycles because of a switch, and SHALL never carry ticks from both channels between the entry to WAIT_NEW and the completion of the switch.
REQ-026 Counter width SHALL be clog2(TMO+1) bits; it increments each cycle while BUSY and saturates at TMO-1.
REQ-027 Timeout in WAIT_OLD: when the counter equals TMO-1 with no old tick, go to WAIT_NEW, clear the counter, no ERR.
REQ-028 Timeout in WAIT_NEW: when the counter equals TMO-1 with no new tick:
- set CUR_SEL=PEND, go to RUN;
- pulse ERR, no SWITCHED, TICK_OUT=0.
REQ-029 CUR_SEL SHALL change only at switch completion or timeout, and SHALL always be < N.
REQ-030 SWITCHED and ERR SHALL never pulse in the same cycle except when an invalid SEL_REQ coincides with a completion; in that case both pulse.

Reset
REQ-031 RST=1 SHALL immediately force the following, regardless of CLK:
- state=RUN, CUR_SEL=RST_SEL, PEND=RST_SEL, counter=0;
- TICK_OUT=0, BUSY=0, SWITCHED=0, ERR=0.
REQ-032 RST asserted mid-switch SHALL abandon the pending switch; no SWITCHED or ERR pulse follows.
REQ-033 First tick forwarding SHALL occur from the first rising edge after RST deasserts.

Verification
REQ-034 N=4, TMO=16, CUR_SEL=0; TICK_IN[0] every 4 cycles -> TICK_OUT pulses every 4 cycles, each one cycle after its input, BUSY=0.
REQ-035 SEL=2 with SEL_REQ; ch0 ticks at +3, ch2 ticks at +5 -> BUSY=1; TICK_OUT at +4 and +6 only; CUR_SEL=2 and SWITCHED=1 at +6; BUSY=0 at +6.
REQ-036 Request SEL=1 from ch0; ch0 and ch1 tick together at +2, ch1 ticks again at +7 -> TICK_OUT at +3 and +8 only; switch completes at +8.
REQ-037 Request SEL=3 from ch0; ch3 stays silent -> WAIT_NEW timeout after 16 cycles; ERR pulses once, CUR_SEL=3, SWITCHED stays 0.
REQ-038 SEL=5 with SEL_REQ (SW=3, N=4) -> ERR pulses once, state stays RUN, CUR_SEL unchanged; a valid SEL_REQ while BUSY is ignored.
REQ-039 RST pulse during WAIT_NEW -> asynchronous return to CUR_SEL=0, BUSY=0, TICK_OUT=0; no SWITCHED or ERR after release.

Source files
------------

// File: rtl/tick_sel_mux.sv
// Glitch-free tick channel selector: switches between one-cycle tick streams only
// at tick boundaries, with a per-phase timeout so a silent channel cannot stall a switch.
module tick_sel_mux #(
   parameter int N       = 4,
   parameter int SW      = 2,
   parameter int TMO     = 1024,
   parameter int RST_SEL = 0
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [N-1:0]  TICK_IN,
   input  logic [SW-1:0] SEL,
   input  logic          SEL_REQ,
   output logic          TICK_OUT,
   output logic [SW-1:0] CUR_SEL,
   output logic          BUSY,
   output logic          SWITCHED,
   output logic          ERR
);

   localparam int            CW       = $clog2(TMO + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);
   localparam logic [SW-1:0] SEL_INIT = SW'(RST_SEL);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      WAIT_OLD = 2'd1,
      WAIT_NEW = 2'd2
   } state_t;

   state_t        r_state;
   logic [SW-1:0] r_curSel;
   logic [SW-1:0] r_pend;
   logic [CW-1:0] r_cnt;
   logic          r_tickOut;
   logic          r_switched;
   logic          r_err;

   state_t        w_nextState;
   logic [SW-1:0] w_nextCur;
   logic [SW-1:0] w_nextPend;
   logic [CW-1:0] w_nextCnt;
   logic [CW-1:0] w_cntInc;
   logic          w_nextTick;
   logic          w_nextSwitched;
   logic          w_nextErr;
   logic          w_curTick;
   logic          w_pendTick;
   logic          w_selInRange;
   logic          w_reqValid;
   logic          w_reqBad;

   // Explicit compare-based muxes keep selects within the N implemented channels.
   always_comb begin
      w_curTick  = 1'b0;
      w_pendTick = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (r_curSel == SW'(i)) w_curTick = TICK_IN[i];
         if (r_pend == SW'(i))   w_pendTick = TICK_IN[i];
      end
   end

   assign w_selInRange = (32'(SEL) < 32'(N));
   assign w_reqValid   = SEL_REQ && w_selInRange;
   assign w_reqBad     = SEL_REQ && !w_selInRange;
   assign w_cntInc     = (r_cnt == CNT_LAST) ? r_cnt : r_cnt + CW'(1);

   always_comb begin
      w_nextState    = r_state;
      w_nextCur      = r_curSel;
      w_nextPend     = r_pend;
      w_nextCnt      = r_cnt;
      w_nextTick     = 1'b0;
      w_nextSwitched = 1'b0;
      w_nextErr      = w_reqBad;
      case (r_state)
         RUN: begin
            w_nextTick = w_curTick;
            w_nextCnt  = '0;
            if (w_reqValid && (SEL != r_curSel)) begin
               w_nextPend  = SEL;
               w_nextState = WAIT_OLD;
            end
         end
         WAIT_OLD: begin
            w_nextTick = w_curTick;
            if (w_curTick || (r_cnt == CNT_LAST)) begin
               w_nextCnt   = '0;
               w_nextState = WAIT_NEW;
            end else begin
               w_nextCnt = w_cntInc;
            end
         end
         WAIT_NEW: begin
            // A new tick right after a forwarded old tick would make a double-width pulse.
            if (w_pendTick && !r_tickOut) begin
               w_nextTick     = 1'b1;
               w_nextCur      = r_pend;
               w_nextSwitched = 1'b1;
               w_nextCnt      = '0;
               w_nextState    = RUN;
            end else if (r_cnt == CNT_LAST) begin
               w_nextCur   = r_pend;
               w_nextErr   = 1'b1;
               w_nextCnt   = '0;
               w_nextState = RUN;
            end else begin
               w_nextCnt = w_cntInc;
            end
         end
         default: begin
            w_nextCnt   = '0;
            w_nextState = RUN;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state    <= RUN;
         r_curSel   <= SEL_INIT;
         r_pend     <= SEL_INIT;
         r_cnt      <= '0;
         r_tickOut  <= 1'b0;
         r_switched <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_nextState;
         r_curSel   <= w_nextCur;
         r_pend     <= w_nextPend;
         r_cnt      <= w_nextCnt;
         r_tickOut  <= w_nextTick;
         r_switched <= w_nextSwitched;
         r_err      <= w_nextErr;
      end
   end

   assign TICK_OUT = r_tickOut;
   assign CUR_SEL  = r_curSel;
   assign BUSY     = (r_state != RUN);
   assign SWITCHED = r_switched;
   assign ERR      = r_err;

endmodule
